// File: rtl/inst_encoder_loader_if.sv
// Field-bundle stream between the boot/test loader and the instruction encoder.
// The master presents a decoded RV32I bundle and the slave answers with in_ready.
interface inst_encoder_loader_if;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_type;
   logic [6:0]  in_opcode;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [31:0] in_imm;
   logic        in_last;

   modport master (
      output in_valid, in_type, in_opcode, in_funct3, in_funct7,
             in_rd, in_rs1, in_rs2, in_imm, in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_type, in_opcode, in_funct3, in_funct7,
             in_rd, in_rs1, in_rs2, in_imm, in_last,
      output in_ready
   );
endinterface

// File: rtl/inst_encoder_loader.sv
// Packs decoded RV32I field bundles into 32-bit words and writes them sequentially
// into instruction memory through a registered write port.
module inst_encoder_loader #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   localparam int unsigned CW         = $clog2(DEPTH_WORDS) + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   inst_encoder_loader_if.slave   bundle,
   output logic                   imem_we,
   output logic [31:0]            imem_addr,
   output logic [31:0]            imem_wdata,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [1:0]             err_code,
   output logic [CW-1:0]          count
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10,
      ERR  = 2'b11
   } state_t;

   localparam logic [1:0] TYPE_I = 2'b00;
   localparam logic [1:0] TYPE_R = 2'b01;
   localparam logic [1:0] TYPE_S = 2'b10;
   localparam logic [1:0] TYPE_B = 2'b11;

   localparam logic [1:0] CODE_NONE  = 2'b00;
   localparam logic [1:0] CODE_RANGE = 2'b01;
   localparam logic [1:0] CODE_ODD   = 2'b10;
   localparam logic [1:0] CODE_OVF   = 2'b11;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH_WORDS);

   state_t             state, state_nx;
   logic               we_nx;
   logic [31:0]        addr_nx, wdata_nx;
   logic [31:0]        next_addr, next_addr_nx;
   logic [CW-1:0]      count_nx;
   logic [1:0]         code_nx;
   logic [31:0]        enc_word;
   logic signed [31:0] imm_s;
   logic               range_bad, odd_bad;
   logic               accept;

   assign imm_s           = bundle.in_imm;
   assign bundle.in_ready = (state == RUN) && (count < DEPTH_C);
   assign accept          = bundle.in_ready && bundle.in_valid && !start;
   assign busy            = (state == RUN);
   assign done            = (state == DONE);
   assign err             = (state == ERR);

   // Field placement is the exact inverse of the core's extractor/immediate extender.
   always_comb begin
      enc_word = '0;
      unique case (bundle.in_type)
         TYPE_I: enc_word = {bundle.in_imm[11:0], bundle.in_rs1, bundle.in_funct3,
                             bundle.in_rd, bundle.in_opcode};
         TYPE_R: enc_word = {bundle.in_funct7, bundle.in_rs2, bundle.in_rs1,
                             bundle.in_funct3, bundle.in_rd, bundle.in_opcode};
         TYPE_S: enc_word = {bundle.in_imm[11:5], bundle.in_rs2, bundle.in_rs1,
                             bundle.in_funct3, bundle.in_imm[4:0], bundle.in_opcode};
         TYPE_B: enc_word = {bundle.in_imm[12], bundle.in_imm[10:5], bundle.in_rs2,
                             bundle.in_rs1, bundle.in_funct3, bundle.in_imm[4:1],
                             bundle.in_imm[11], bundle.in_opcode};
         default: enc_word = '0;
      endcase
   end

   // B offsets must be even; range failure takes priority over oddness.
   always_comb begin
      range_bad = 1'b0;
      odd_bad   = 1'b0;
      unique case (bundle.in_type)
         TYPE_I, TYPE_S: range_bad = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
         TYPE_B: begin
            range_bad = (imm_s < -32'sd4096) || (imm_s > 32'sd4094);
            odd_bad   = bundle.in_imm[0];
         end
         default: begin
            range_bad = 1'b0;
            odd_bad   = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_nx     = state;
      we_nx        = 1'b0;
      addr_nx      = imem_addr;
      wdata_nx     = imem_wdata;
      next_addr_nx = next_addr;
      count_nx     = count;
      code_nx      = err_code;
      if (start) begin
         state_nx     = RUN;
         next_addr_nx = BASE_ADDR;
         count_nx     = '0;
         code_nx      = CODE_NONE;
      end else if (accept) begin
         if (range_bad) begin
            state_nx = ERR;
            code_nx  = CODE_RANGE;
         end else if (odd_bad) begin
            state_nx = ERR;
            code_nx  = CODE_ODD;
         end else begin
            we_nx        = 1'b1;
            addr_nx      = next_addr;
            wdata_nx     = enc_word;
            next_addr_nx = next_addr + 32'd4;
            count_nx     = count + CW'(1);
            if (bundle.in_last) begin
               state_nx = DONE;
            end else if (count_nx == DEPTH_C) begin
               state_nx = ERR;
               code_nx  = CODE_OVF;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         imem_we    <= 1'b0;
         imem_addr  <= BASE_ADDR;
         imem_wdata <= '0;
         next_addr  <= BASE_ADDR;
         count      <= '0;
         err_code   <= CODE_NONE;
      end else begin
         state      <= state_nx;
         imem_we    <= we_nx;
         imem_addr  <= addr_nx;
         imem_wdata <= wdata_nx;
         next_addr  <= next_addr_nx;
         count      <= count_nx;
         err_code   <= code_nx;
      end
   end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed and randomized checks of the instruction encoder/loader; written words
// are decoded back into fields and compared with the bundles that produced them.
module tb_inst_encoder_loader;
   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int          NRT  = 30;

   typedef struct packed {
      logic [1:0]  typ;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } bundle_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start1 = 1'b0;
   logic start2 = 1'b0;

   logic        we1, busy1, done1, err1;
   logic [31:0] addr1, wdata1;
   logic [1:0]  code1;
   logic [8:0]  count1;
   logic        we2, busy2, done2, err2;
   logic [31:0] addr2, wdata2;
   logic [1:0]  code2;
   logic [2:0]  count2;

   int      total = 0;
   int      bad = 0;
   wr_t     wq1[$];
   bundle_t exp_q[$];
   int      wn2 = 0;

   inst_encoder_loader_if bus1 ();
   inst_encoder_loader_if bus2 ();

   inst_encoder_loader #(.DEPTH_WORDS(256), .BASE_ADDR(BASE)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .bundle(bus1),
      .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1),
      .busy(busy1), .done(done1), .err(err1), .err_code(code1), .count(count1)
   );

   inst_encoder_loader #(.DEPTH_WORDS(4), .BASE_ADDR(BASE)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .bundle(bus2),
      .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2),
      .busy(busy2), .done(done2), .err(err2), .err_code(code2), .count(count2)
   );

   always #5 clk = ~clk;

   // Memory-side view: a write lands on the edge that closes its strobe cycle.
   always @(posedge clk) if (we1) wq1.push_back({addr1, wdata1});
   always @(posedge clk) if (we2) wn2++;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input bundle_t b, input logic last);
      bus1.in_type   = b.typ;
      bus1.in_opcode = b.op;
      bus1.in_funct3 = b.f3;
      bus1.in_funct7 = b.f7;
      bus1.in_rd     = b.rd;
      bus1.in_rs1    = b.rs1;
      bus1.in_rs2    = b.rs2;
      bus1.in_imm    = b.imm;
      bus1.in_last   = last;
   endtask

   task automatic pulse_start1();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
   endtask

   function automatic bundle_t mk(input logic [1:0] t, input logic [6:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [31:0] imm);
      bundle_t b;
      b.typ = t; b.op = op; b.f3 = f3; b.f7 = f7;
      b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.imm = imm;
      return b;
   endfunction

   function automatic bundle_t rand_bundle();
      bundle_t b;
      int      v;
      b.typ = 2'($urandom_range(3));
      b.op  = 7'($urandom);
      b.f3  = 3'($urandom);
      b.f7  = 7'($urandom);
      b.rd  = 5'($urandom);
      b.rs1 = 5'($urandom);
      b.rs2 = 5'($urandom);
      v = int'($urandom_range(4095)) - 2048;
      if (b.typ == 2'b11) b.imm = 32'(v * 2);
      else if (b.typ == 2'b01) b.imm = $urandom;
      else b.imm = 32'(v);
      return b;
   endfunction

   // Immediate as the core's extender rebuilds it from an encoded word.
   function automatic logic [31:0] ref_imm(input logic [1:0] t, input logic [31:0] w);
      case (t)
         2'b00:   return {{20{w[31]}}, w[31:20]};
         2'b10:   return {{20{w[31]}}, w[31:25], w[11:7]};
         2'b11:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
         default: return 32'h0;
      endcase
   endfunction

   function automatic wr_t get_wr(input int i);
      if (i < wq1.size()) return wq1[i];
      return '1;
   endfunction

   initial begin
      bundle_t b;
      wr_t     w;

      apply_stimulus('0, 1'b0);
      bus1.in_valid = 1'b0;
      bus2.in_valid = 1'b0; bus2.in_type = 2'b01; bus2.in_opcode = 7'h33;
      bus2.in_funct3 = 3'h0; bus2.in_funct7 = 7'h00; bus2.in_rd = 5'd3;
      bus2.in_rs1 = 5'd1; bus2.in_rs2 = 5'd2; bus2.in_imm = 32'h0; bus2.in_last = 1'b0;

      tick(2);
      check_output("rst_ready", 32'(bus1.in_ready), 32'd0);
      check_output("rst_we", 32'(we1), 32'd0);
      check_output("rst_addr", addr1, BASE);
      check_output("rst_wdata", wdata1, 32'h0);
      check_output("rst_flags", {28'd0, busy1, done1, err1, 1'b0}, 32'd0);
      check_output("rst_code", 32'(code1), 32'd0);
      check_output("rst_count", 32'(count1), 32'd0);
      rst_n = 1'b1;
      tick();

      // addi x1,x0,5
      pulse_start1();
      check_output("run_busy", 32'(busy1), 32'd1);
      check_output("run_ready", 32'(bus1.in_ready), 32'd1);
      apply_stimulus(mk(2'b00, 7'h13, 3'h0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd5), 1'b0);
      bus1.in_valid = 1'b1;
      tick();
      bus1.in_valid = 1'b0;
      check_output("addi_we", 32'(we1), 32'd1);
      check_output("addi_addr", addr1, 32'h0);
      check_output("addi_wdata", wdata1, 32'h0050_0093);
      check_output("addi_count", 32'(count1), 32'd1);

      // start while the addi write is on the port: write still lands, then strobe drops
      pulse_start1();
      check_output("start_we", 32'(we1), 32'd0);
      check_output("start_count", 32'(count1), 32'd0);
      check_output("start_kept_write", get_wr(0).data, 32'h0050_0093);
      wq1.delete();

      // add, sw, beq back-to-back with last on beq
      bus1.in_valid = 1'b1;
      apply_stimulus(mk(2'b01, 7'h33, 3'h0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0), 1'b0);
      tick();
      apply_stimulus(mk(2'b10, 7'h23, 3'h2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8), 1'b0);
      tick();
      apply_stimulus(mk(2'b11, 7'h63, 3'h0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8), 1'b1);
      tick();
      bus1.in_valid = 1'b0;
      check_output("stream_done", 32'(done1), 32'd1);
      check_output("stream_busy", 32'(busy1), 32'd0);
      check_output("stream_count", 32'(count1), 32'd3);
      check_output("stream_ready", 32'(bus1.in_ready), 32'd0);
      tick(2);
      check_output("stream_nwr", 32'(wq1.size()), 32'd3);
      check_output("stream_w0", get_wr(0).data, 32'h0020_81B3);
      check_output("stream_a0", get_wr(0).addr, 32'h0);
      check_output("stream_w1", get_wr(1).data, 32'h0020_A423);
      check_output("stream_a1", get_wr(1).addr, 32'h4);
      check_output("stream_w2", get_wr(2).data, 32'hFE20_8CE3);
      check_output("stream_a2", get_wr(2).addr, 32'h8);

      // Random legal bundles with idle gaps; every word must decode back to its bundle.
      pulse_start1();
      wq1.delete();
      for (int i = 0; i < NRT; i++) begin
         b = rand_bundle();
         while ($urandom_range(3) == 0) begin
            bus1.in_valid = 1'b0;
            tick();
         end
         apply_stimulus(b, i == NRT - 1);
         bus1.in_valid = 1'b1;
         check_output("rt_ready", 32'(bus1.in_ready), 32'd1);
         tick();
         exp_q.push_back(b);
      end
      bus1.in_valid = 1'b0;
      tick(2);
      check_output("rt_done", 32'(done1), 32'd1);
      check_output("rt_count", 32'(count1), 32'(NRT));
      check_output("rt_nwr", 32'(wq1.size()), 32'(NRT));
      for (int i = 0; i < NRT; i++) begin
         w = get_wr(i);
         b = exp_q[i];
         check_output("rt_addr", w.addr, BASE + 32'(4 * i));
         check_output("rt_opcode", 32'(w.data[6:0]), 32'(b.op));
         check_output("rt_funct3", 32'(w.data[14:12]), 32'(b.f3));
         check_output("rt_rs1", 32'(w.data[19:15]), 32'(b.rs1));
         if (b.typ == 2'b00 || b.typ == 2'b01) check_output("rt_rd", 32'(w.data[11:7]), 32'(b.rd));
         if (b.typ != 2'b00) check_output("rt_rs2", 32'(w.data[24:20]), 32'(b.rs2));
         if (b.typ == 2'b01) check_output("rt_funct7", 32'(w.data[31:25]), 32'(b.f7));
         else check_output("rt_imm", ref_imm(b.typ, w.data), b.imm);
      end

      // I-type immediate just past the top of range
      pulse_start1();
      wq1.delete();
      apply_stimulus(mk(2'b00, 7'h13, 3'h0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd2048), 1'b0);
      bus1.in_valid = 1'b1;
      tick();
      bus1.in_valid = 1'b0;
      check_output("i2048_err", 32'(err1), 32'd1);
      check_output("i2048_code", 32'(code1), 32'd1);
      check_output("i2048_ready", 32'(bus1.in_ready), 32'd0);
      check_output("i2048_busy", 32'(busy1), 32'd0);
      check_output("i2048_we", 32'(we1), 32'd0);
      tick();
      check_output("i2048_nwr", 32'(wq1.size()), 32'd0);

      // start coincident with valid: the bundle waits for the next cycle
      apply_stimulus(mk(2'b10, 7'h23, 3'h2, 7'h0, 5'd0, 5'd4, 5'd5, 32'hFFFF_F800), 1'b0);
      bus1.in_valid = 1'b1;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check_output("coinc_we", 32'(we1), 32'd0);
      check_output("coinc_busy", 32'(busy1), 32'd1);
      check_output("coinc_err", 32'(err1), 32'd0);
      tick();
      check_output("sneg_we", 32'(we1), 32'd1);
      check_output("sneg_addr", addr1, 32'h0);
      check_output("sneg_imm", ref_imm(2'b10, wdata1), 32'hFFFF_F800);
      apply_stimulus(mk(2'b11, 7'h63, 3'h1, 7'h0, 5'd0, 5'd6, 5'd7, 32'd6), 1'b0);
      tick();
      check_output("b6_we", 32'(we1), 32'd1);
      check_output("b6_addr", addr1, 32'h4);
      check_output("b6_imm", ref_imm(2'b11, wdata1), 32'd6);
      apply_stimulus(mk(2'b11, 7'h63, 3'h1, 7'h0, 5'd0, 5'd6, 5'd7, 32'd7), 1'b0);
      tick();
      bus1.in_valid = 1'b0;
      check_output("b7_err", 32'(err1), 32'd1);
      check_output("b7_code", 32'(code1), 32'd2);
      check_output("b7_we", 32'(we1), 32'd0);
      check_output("b7_count", 32'(count1), 32'd2);

      // Odd and out of range: range wins
      pulse_start1();
      apply_stimulus(mk(2'b11, 7'h63, 3'h0, 7'h0, 5'd0, 5'd1, 5'd2, 32'd4095), 1'b0);
      bus1.in_valid = 1'b1;
      tick();
      bus1.in_valid = 1'b0;
      check_output("b4095_code", 32'(code1), 32'd1);
      check_output("b4095_we", 32'(we1), 32'd0);

      // Overflow on the four-word instance
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      wn2 = 0;
      bus2.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check_output("ovf_ready", 32'(bus2.in_ready), (i < 4) ? 32'd1 : 32'd0);
         tick();
      end
      bus2.in_valid = 1'b0;
      check_output("ovf_err", 32'(err2), 32'd1);
      check_output("ovf_code", 32'(code2), 32'd3);
      check_output("ovf_count", 32'(count2), 32'd4);
      check_output("ovf_we", 32'(we2), 32'd0);
      tick();
      check_output("ovf_nwr", 32'(wn2), 32'd4);

      // Asynchronous reset in the middle of a stream
      pulse_start1();
      wq1.delete();
      bus1.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(mk(2'b01, 7'h33, 3'h0, 7'h20, 5'(i + 1), 5'd1, 5'd2, 32'h0), 1'b0);
         tick();
      end
      #2;
      rst_n = 1'b0;
      #1;
      bus1.in_valid = 1'b0;
      check_output("arst_we", 32'(we1), 32'd0);
      check_output("arst_addr", addr1, BASE);
      check_output("arst_wdata", wdata1, 32'h0);
      check_output("arst_count", 32'(count1), 32'd0);
      check_output("arst_state", {28'd0, busy1, done1, err1, bus1.in_ready}, 32'd0);
      tick();
      check_output("arst_nwr", 32'(wq1.size()), 32'd2);
      rst_n = 1'b1;
      tick();
      pulse_start1();
      apply_stimulus(mk(2'b00, 7'h13, 3'h0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd5), 1'b1);
      bus1.in_valid = 1'b1;
      tick();
      bus1.in_valid = 1'b0;
      check_output("post_we", 32'(we1), 32'd1);
      check_output("post_addr", addr1, BASE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/inst_encoder_loader.md
# inst_encoder_loader

Instruction encoder and instruction-memory loader for the single-cycle RV32I core. It accepts decoded instruction fields (type, opcode, funct, register indices, immediate) over a valid/ready stream and packs each into a 32-bit RV32I word. It then writes the words sequentially into instruction memory through a registered write port. Its type encoding and field placement are the exact inverse of the core's field extractor/immediate extender, so every word round-trips through the decoder. Used by the boot/test loader ahead of core reset release.

## Interface
- DEPTH_WORDS, 256, instruction-memory capacity in words; overflow limit.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written after start.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load session from BASE_ADDR.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- in_type  in  2  00 I, 01 R, 10 S, 11 B.
- in_opcode  in  7  inst[6:0].
- in_funct3  in  3  inst[14:12].
- in_funct7  in  7  inst[31:25]; used for R only.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  signed immediate, byte offset for B.
- in_last  in  1  marks the final bundle of the session.
- imem_we  out  1  write strobe, one cycle per word.
- imem_addr  out  32  byte address, word aligned.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  session active (RUN).
- done  out  1  session completed; held until next start.
- err  out  1  session aborted; sticky until next start.
- err_code  out  2  01 imm out of range, 10 B offset odd, 11 overflow, 00 none.
- count  out  clog2(DEPTH_WORDS)+1  words written this session.

## Operation
- States: IDLE, RUN, DONE, ERR. Reset enters IDLE.
- Reset values: in_ready 0, imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, busy 0, done 0, err 0, err_code 00, count 0.
- Transitions on start from any state: to RUN. start clears done, err, err_code and count, and sets the next address to BASE_ADDR.
- in_ready is 1 only in RUN with count < DEPTH_WORDS.
- A bundle is accepted when in_valid && in_ready.
- Encoding by type:
  - I: imm[11:0], rs1, funct3, rd, opcode.
  - R: funct7, rs2, rs1, funct3, rd, opcode.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
- Range check: I and S require in_imm in [-2048, 2047]. B requires [-4096, 4094] and imm[0]=0. R ignores in_imm.
- Check failure on an accepted bundle:
  - No write is made.
  - State goes to ERR.
  - err_code is 01, or 10 when the value is in range but odd. Range failure wins over odd.
- Valid bundle: register the write, then increment the address by 4 and count by 1.
  - If in_last is set, go to DONE.
  - Otherwise, if count reaches DEPTH_WORDS, go to ERR with code 11.
- Outside RUN, in_valid is ignored.
- In RUN with count < DEPTH_WORDS, valid bundles may stream back-to-back.

## Timing
- Bundle accepted at edge N: imem_we=1 with addr/wdata valid for the cycle after N. imem_we deasserts after one cycle unless another bundle was accepted at edge N+1.
- Throughput is one word per cycle. Latency is 1 cycle from accept to write strobe.
- count, done and err update at the same edge as the write register.
- busy is 1 throughout RUN. It falls at the edge that accepts the last bundle or detects the error.
- A start asserted while a write strobe is presented does not cancel that write. The next cycle has imem_we=0 unless a bundle was accepted.
- start coincident with in_valid: the bundle is not accepted (in_ready was 0, or the session restarts).
- Asynchronous rst_n assertion mid-session: all outputs immediately take their reset values, and any pending write is dropped.

## Test plan
- Start; send I-type addi x1,x0,5 (opcode 0010011, funct3 000, imm 5). Required response, next cycle: we=1, addr 0, wdata 32'h0050_0093, count 1.
- Stream R add x3,x1,x2, then S sw x2,8(x1), then B beq x1,x2,-8 with last on B, back-to-back. Required response:
  - Writes 32'h0020_81B3 @0, 32'h0020_A423 @4, 32'hFE20_8CE3 @8.
  - done=1, busy=0, count 3.
- Round-trip: send random legal bundles. Each written word fed to the core's field extractor must return the same rs1/rd/rs2 (rs2 for R/S/B), and the immediate must equal in_imm.
- Send I-type with imm 2048. Required response: no write, err=1, err_code 01, in_ready=0. Send B with imm 6, odd variant imm 7. Required response: 7 gives err_code 10.
- DEPTH_WORDS=4, send 5 bundles without last. Required response: 4 writes, err_code 11, 5th not accepted.
- Assert rst_n low during a stream. Required response: outputs immediately at reset values. After start, addr restarts at BASE_ADDR.
